// File: rtl/i2so_sched.sv
//------------------------------------------------------------------------------
// Module      : i2so_sched
// Description : I2S output scheduler. Generates the serial bit clock, buffers
//               stereo samples from one of two sources, and presents them to
//               the serializer frame by frame.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module i2so_sched #(
    parameter int DIV_W     = 8,
    parameter int AW        = 2,
    parameter int PRIME_LVL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    input  logic             src_sel,
    input  logic             s0_valid,
    input  logic [15:0]      s0_lft,
    input  logic [15:0]      s0_rgt,
    output logic             s0_ready,
    input  logic             s1_valid,
    input  logic [15:0]      s1_lft,
    input  logic [15:0]      s1_rgt,
    output logic             s1_ready,
    input  logic             rtr,
    output logic             rts,
    output logic             i2si_sck,
    output logic [15:0]      i2so_lft,
    output logic [15:0]      i2so_rgt,
    output logic             active_src,
    output logic             underrun,
    output logic [AW:0]      fifo_level
);

    localparam int          c_depth     = 1 << AW;
    localparam logic [AW:0] c_full_lvl  = (AW+1)'(c_depth);
    localparam logic [AW:0] c_prime_lvl = (AW+1)'(PRIME_LVL);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_prime = 2'd1;
    localparam logic [1:0] c_run   = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_lat;
    logic             r_sck;
    logic             r_rts;
    logic             r_src;
    logic             r_underrun;
    logic [15:0]      r_lft;
    logic [15:0]      r_rgt;
    logic [31:0]      r_mem [c_depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic [DIV_W-1:0] w_eff_div;
    logic             w_running;
    logic             w_full;
    logic             w_empty;
    logic             w_s0_ready;
    logic             w_s1_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;
    logic [31:0]      w_push_data;
    logic [31:0]      w_head;

    // Clamp keeps each sck phase long enough for the serializer's synchronizer
    assign w_eff_div   = (div < DIV_W'(3)) ? DIV_W'(3) : div;
    assign w_running   = (r_state == c_prime) || (r_state == c_run);
    assign w_full      = (r_level == c_full_lvl);
    assign w_empty     = (r_level == '0);
    assign w_s0_ready  = w_running && !w_full && !r_src;
    assign w_s1_ready  = w_running && !w_full && r_src;
    assign w_push      = (s0_valid && w_s0_ready) || (s1_valid && w_s1_ready);
    assign w_push_data = r_src ? {s1_lft, s1_rgt} : {s0_lft, s0_rgt};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_pop       = ((r_state == c_prime) && en && (r_level >= c_prime_lvl)) ||
                         ((r_state == c_run) && rtr && !w_empty);
    assign w_flush     = ((r_state == c_prime) && !en) || ((r_state == c_drain) && rtr);

    // Divider value is latched at each wrap so mid-count changes wait a phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_sck     <= 1'b0;
            r_div_lat <= DIV_W'(3);
        end else if (r_state == c_idle) begin
            r_cnt     <= '0;
            r_sck     <= 1'b0;
            r_div_lat <= w_eff_div;
        end else if (r_cnt >= r_div_lat) begin
            r_cnt     <= '0;
            r_sck     <= ~r_sck;
            r_div_lat <= w_eff_div;
        end else begin
            r_cnt     <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

    // Pop is taken from the stored head only, so a push never bypasses to the output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_idle;
            r_rts      <= 1'b0;
            r_src      <= 1'b0;
            r_underrun <= 1'b0;
            r_lft      <= '0;
            r_rgt      <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (en) begin
                        r_state    <= c_prime;
                        r_underrun <= 1'b0;
                        r_src      <= src_sel;
                    end
                end
                c_prime: begin
                    if (!en) begin
                        r_state <= c_idle;
                    end else if (r_level >= c_prime_lvl) begin
                        r_lft   <= w_head[31:16];
                        r_rgt   <= w_head[15:0];
                        r_rts   <= 1'b1;
                        r_state <= c_run;
                    end
                end
                c_run: begin
                    if (rtr) begin
                        r_src <= src_sel;
                        if (!w_empty) begin
                            r_lft <= w_head[31:16];
                            r_rgt <= w_head[15:0];
                        end else begin
                            r_lft      <= '0;
                            r_rgt      <= '0;
                            r_underrun <= 1'b1;
                        end
                        if (!en) r_state <= c_drain;
                    end
                end
                c_drain: begin
                    if (rtr) begin
                        r_lft   <= '0;
                        r_rgt   <= '0;
                        r_rts   <= 1'b0;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign s0_ready   = w_s0_ready;
    assign s1_ready   = w_s1_ready;
    assign rts        = r_rts;
    assign i2si_sck   = r_sck;
    assign i2so_lft   = r_lft;
    assign i2so_rgt   = r_rgt;
    assign active_src = r_src;
    assign underrun   = r_underrun;
    assign fifo_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_i2so_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_i2so_sched
// Description : Randomized bench for i2so_sched against a queue-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_i2so_sched;

    localparam int c_depth = 4;
    localparam int c_prime = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  div;
    logic        src_sel;
    logic        s0_valid;
    logic [15:0] s0_lft;
    logic [15:0] s0_rgt;
    logic        s0_ready;
    logic        s1_valid;
    logic [15:0] s1_lft;
    logic [15:0] s1_rgt;
    logic        s1_ready;
    logic        rtr;
    logic        rts;
    logic        i2si_sck;
    logic [15:0] i2so_lft;
    logic [15:0] i2so_rgt;
    logic        active_src;
    logic        underrun;
    logic [2:0]  fifo_level;

    i2so_sched #(.DIV_W(8), .AW(2), .PRIME_LVL(c_prime)) u_dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .src_sel(src_sel),
        .s0_valid(s0_valid), .s0_lft(s0_lft), .s0_rgt(s0_rgt), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_lft(s1_lft), .s1_rgt(s1_rgt), .s1_ready(s1_ready),
        .rtr(rtr), .rts(rts), .i2si_sck(i2si_sck), .i2so_lft(i2so_lft),
        .i2so_rgt(i2so_rgt), .active_src(active_src), .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: 0 idle, 1 priming, 2 playing, 3 draining; FIFO is a queue
    int          m_mode;
    logic [31:0] m_q [$];
    logic [15:0] m_lft, m_rgt;
    bit          m_rts, m_src, m_und, m_sck;
    int          m_since, m_half;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int half_period(input logic [7:0] d);
        return ((d < 3) ? 3 : int'(d)) + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_q.delete(); m_lft = '0; m_rgt = '0;
        m_rts = 0; m_src = 0; m_und = 0; m_sck = 0; m_since = 0; m_half = 4;
    endtask

    task automatic model_step();
        bit          running, rdy0, rdy1, push, flush;
        logic [31:0] word, head;
        running = (m_mode == 1) || (m_mode == 2);
        rdy0    = running && (m_q.size() < c_depth) && !m_src;
        rdy1    = running && (m_q.size() < c_depth) && m_src;
        push    = (s0_valid && rdy0) || (s1_valid && rdy1);
        word    = m_src ? {s1_lft, s1_rgt} : {s0_lft, s0_rgt};
        flush   = 0;
        if (m_mode == 0) begin
            m_sck = 0; m_since = 0; m_half = half_period(div);
        end else if (m_since + 1 == m_half) begin
            m_sck = !m_sck; m_since = 0; m_half = half_period(div);
        end else begin
            m_since++;
        end
        case (m_mode)
            0: if (en) begin m_mode = 1; m_und = 0; m_src = src_sel; end
            1: begin
                if (!en) begin
                    m_mode = 0; flush = 1;
                end else if (m_q.size() >= c_prime) begin
                    head = m_q.pop_front();
                    m_lft = head[31:16]; m_rgt = head[15:0];
                    m_rts = 1; m_mode = 2;
                end
            end
            2: if (rtr) begin
                m_src = src_sel;
                if (m_q.size() > 0) begin
                    head = m_q.pop_front();
                    m_lft = head[31:16]; m_rgt = head[15:0];
                end else begin
                    m_lft = '0; m_rgt = '0; m_und = 1;
                end
                if (!en) m_mode = 3;
            end
            default: if (rtr) begin
                m_lft = '0; m_rgt = '0; m_rts = 0; m_mode = 0; flush = 1;
            end
        endcase
        if (push) m_q.push_back(word);
        if (flush) m_q.delete();
    endtask

    task automatic check_all();
        bit running;
        running = (m_mode == 1) || (m_mode == 2);
        check_val("rts",        32'(rts),        32'(m_rts));
        check_val("sck",        32'(i2si_sck),   32'(m_sck));
        check_val("lft",        32'(i2so_lft),   32'(m_lft));
        check_val("rgt",        32'(i2so_rgt),   32'(m_rgt));
        check_val("active_src", 32'(active_src), 32'(m_src));
        check_val("underrun",   32'(underrun),   32'(m_und));
        check_val("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check_val("s0_ready",   32'(s0_ready),   32'(running && m_q.size() < c_depth && !m_src));
        check_val("s1_ready",   32'(s1_ready),   32'(running && m_q.size() < c_depth && m_src));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1; rtr = 1'b0; en = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_phase(input int n, input int p_valid, input int p_rtr, input int p_off);
        for (int i = 0; i < n; i++) begin
            s0_valid = ($urandom_range(0, 99) < p_valid);
            s1_valid = ($urandom_range(0, 99) < p_valid);
            s0_lft = 16'($urandom); s0_rgt = 16'($urandom);
            s1_lft = 16'($urandom); s1_rgt = 16'($urandom);
            rtr = !rtr && ($urandom_range(0, 99) < p_rtr);
            if (en) en = !($urandom_range(0, 999) < p_off);
            else    en = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 3) src_sel = !src_sel;
            if ($urandom_range(0, 99) < 2) div = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 999) == 0) do_reset();
            else step();
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = 8'd3; src_sel = 1'b0; rtr = 1'b0;
        s0_valid = 1'b0; s0_lft = '0; s0_rgt = '0;
        s1_valid = 1'b0; s1_lft = '0; s1_rgt = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Prime with two words from source 0, then play and underrun
        en = 1'b1; step();
        s0_valid = 1'b1; s0_lft = 16'h1111; s0_rgt = 16'h2222; step();
        s0_lft = 16'h3333; s0_rgt = 16'h4444; step();
        s0_valid = 1'b0; step();
        check_val("plan_lft", 32'(i2so_lft), 32'h1111);
        check_val("plan_rgt", 32'(i2so_rgt), 32'h2222);
        check_val("plan_level", 32'(fifo_level), 32'd1);
        for (int i = 0; i < 12; i++) step();
        rtr = 1'b1; step(); rtr = 1'b0; step();
        rtr = 1'b1; step(); rtr = 1'b0; step();
        check_val("plan_underrun", 32'(underrun), 32'd1);

        // Source switch mid-frame, then fill to full with valid held high
        src_sel = 1'b1; for (int i = 0; i < 5; i++) step();
        rtr = 1'b1; step(); rtr = 1'b0;
        s1_valid = 1'b1;
        for (int i = 0; i < 8; i++) step();
        rtr = 1'b1; step(); rtr = 1'b0; step();
        s1_valid = 1'b0;

        // Clamped divider and mid-count divider change
        div = 8'd0; for (int i = 0; i < 20; i++) step();
        div = 8'd3; for (int i = 0; i < 6; i++) step();
        div = 8'd7; for (int i = 0; i < 30; i++) step();

        // Drain sequence
        en = 1'b0; step();
        rtr = 1'b1; step(); rtr = 1'b0; step(); step();
        rtr = 1'b1; step(); rtr = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_val("drain_rts", 32'(rts), 32'd0);

        // Mid-run reset
        en = 1'b1; s0_valid = 1'b1; src_sel = 1'b0;
        for (int i = 0; i < 10; i++) step();
        do_reset();

        rand_phase(2000, 50, 15, 5);
        rand_phase(1000, 90, 5, 2);
        rand_phase(1000, 10, 40, 5);
        rand_phase(1000, 60, 25, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
